// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmitter among N_REQ byte requesters.
// Optional watchdog in WAIT_DONE enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 8192
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          req_lock,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    input  logic                      tx_done,
    output logic [$clog2(N_REQ)-1:0]  owner,
    output logic                      active,
    output logic                      timeout_err
);

    localparam int unsigned IdxW = $clog2(N_REQ);

    typedef enum logic [1:0] {StIdle, StLaunch, StWaitDone} state_e;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
    end

    state_e            state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              active_q, active_d;

    logic [DATA_W-1:0] req_bytes [N_REQ];
    logic [N_REQ-1:0]  low_mask, masked_req;
    logic [IdxW-1:0]   winner;
    logic [IdxW-1:0]   ptr_next;

    for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Requests at or above ptr take priority; fall back to the lowest request overall.
    always_comb begin
        low_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            low_mask[i] = (i >= int'(ptr_q));
        end
        masked_req = req & low_mask;
        winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (masked_req != '0) begin
                if (masked_req[i]) winner = IdxW'(i);
            end else if (req[i]) begin
                winner = IdxW'(i);
            end
        end
    end

    assign ptr_next = (owner_q == IdxW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_err_q, timeout_err_d;

    // Counter holds zero outside WAIT_DONE, so it restarts on every entry.
    assign wd_cnt_d = (state_q == StWaitDone) ? wd_cnt_q + 32'd1 : 32'd0;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        tx_data_d  = tx_data_q;
        ack_d      = '0;
        tx_start_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        timeout_err_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (req != '0 && !tx_busy) begin
                    owner_d       = winner;
                    tx_data_d     = req_bytes[winner];
                    tx_start_d    = 1'b1;
                    ack_d[winner] = 1'b1;
                    state_d       = StLaunch;
                end
            end
            StLaunch: begin
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (tx_done) begin
                    if (req_lock[owner_q] && req[owner_q]) begin
                        tx_data_d      = req_bytes[owner_q];
                        tx_start_d     = 1'b1;
                        ack_d[owner_q] = 1'b1;
                        state_d        = StLaunch;
                    end else begin
                        ptr_d   = ptr_next;
                        state_d = StIdle;
                    end
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d = 1'b1;
                    ptr_d         = ptr_next;
                    state_d       = StIdle;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
        active_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            owner_q    <= '0;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            ack_q      <= ack_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            active_q   <= active_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign ack      = ack_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign owner    = owner_q;
    assign active   = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req, req_lock, ack;
    logic [N*DW-1:0] req_data;
    logic            tx_start, tx_busy, tx_done, active, timeout_err;
    logic [DW-1:0]   tx_data;
    logic [1:0]      owner;

    int errors = 0;
    int checks = 0;
    int m_ptr  = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ          (N),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_lock    (req_lock),
        .req_data    (req_data),
        .ack         (ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .owner       (owner),
        .active      (active),
        .timeout_err (timeout_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: first requester at or after ptr, wrapping around.
    function automatic int pick(input int p, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] v;
        v    = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] get_byte(input int i);
        return req_data[i*DW +: DW];
    endfunction

    task automatic set_byte(input int i, input logic [DW-1:0] b);
        req_data[i*DW +: DW] = b;
    endtask

    task automatic expect_grant(input int w, input logic [DW-1:0] b, input string tag);
        check({tag, ".ack"}, 32'(ack), 32'(onehot(w)));
        check({tag, ".tx_start"}, 32'(tx_start), 32'd1);
        check({tag, ".tx_data"}, 32'(tx_data), 32'(b));
        check({tag, ".owner"}, 32'(owner), 32'(w));
        check({tag, ".active"}, 32'(active), 32'd1);
        check({tag, ".timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    task automatic expect_quiet(input logic act, input string tag);
        check({tag, ".ack"}, 32'(ack), 32'd0);
        check({tag, ".tx_start"}, 32'(tx_start), 32'd0);
        check({tag, ".active"}, 32'(active), 32'(act));
        check({tag, ".timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    task automatic expect_reset_outputs(input string tag);
        expect_quiet(1'b0, tag);
        check({tag, ".tx_data"}, 32'(tx_data), 32'd0);
        check({tag, ".owner"}, 32'(owner), 32'd0);
    endtask

    task automatic apply_reset();
        req      = '0;
        req_lock = '0;
        tx_busy  = 1'b0;
        tx_done  = 1'b0;
        rst_n    = 1'b0;
        #1;
        expect_reset_outputs("reset");
        step();
        step();
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    // Grant from IDLE: inputs already applied; returns the model winner and its byte.
    task automatic do_grant(input string tag, output int w, output logic [DW-1:0] b);
        w = pick(m_ptr, req);
        b = get_byte(w);
        step();
        expect_grant(w, b, tag);
    endtask

    // Called in the LAUNCH cycle; runs the frame and checks the completion outcome.
    task automatic serve_frame(input int w, input int waitc, input bit early_done,
                               input logic [DW-1:0] lb, input string tag,
                               output bit relaunched);
        tx_done = early_done;
        step();
        tx_done = 1'b0;
        expect_quiet(1'b1, {tag, ".launch"});
        for (int c = 0; c < waitc; c++) begin
            tx_busy = 1'b1;
            step();
            expect_quiet(1'b1, {tag, ".wait"});
        end
        check({tag, ".hold_data"}, 32'(tx_data), 32'(lb));
        tx_done    = 1'b1;
        tx_busy    = 1'b0;
        relaunched = req_lock[w] && req[w];
        step();
        tx_done = 1'b0;
        if (relaunched) begin
            expect_grant(w, get_byte(w), {tag, ".relock"});
        end else begin
            expect_quiet(1'b0, {tag, ".done"});
            m_ptr = (w + 1) % N;
        end
    endtask

    initial begin
        int            w;
        logic [DW-1:0] lb;
        bit            rl;
        int            exp_order [5] = '{0, 1, 2, 3, 0};

        req_data = '0;
        apply_reset();

        // Single requester
        req = 4'b0001;
        set_byte(0, 8'h5A);
        do_grant("single", w, lb);
        check("single.byte", 32'(tx_data), 32'h5A);
        req = '0;
        serve_frame(w, 3, 1'b0, lb, "single", rl);

        // Contention with all requesters, fresh byte after each ack
        apply_reset();
        req = 4'b1111;
        for (int i = 0; i < N; i++) set_byte(i, DW'($urandom));
        for (int g = 0; g < 5; g++) begin
            do_grant("cont", w, lb);
            check("cont.order", 32'(owner), 32'(exp_order[g]));
            set_byte(w, DW'($urandom));
            serve_frame(w, 12, 1'b0, lb, "cont", rl);
        end

        // Locked 3-byte packet from requester 2 while requester 0 waits
        req      = 4'b0101;
        req_lock = 4'b0100;
        do_grant("lock", w, lb);
        check("lock.first_owner", 32'(owner), 32'd2);
        for (int k = 0; k < 3; k++) begin
            if (k < 2) begin
                set_byte(2, DW'($urandom));
            end else begin
                req[2]      = 1'b0;
                req_lock[2] = 1'b0;
            end
            serve_frame(w, 4, 1'b0, lb, "lock", rl);
            lb = get_byte(w);
        end
        do_grant("lock.after", w, lb);
        check("lock.after_owner", 32'(owner), 32'd0);
        req = '0;
        serve_frame(w, 2, 1'b0, lb, "lock.after", rl);

        // Busy transmitter blocks grants; withdrawn request never granted
        tx_busy = 1'b1;
        req     = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            step();
            expect_quiet(1'b0, "busy");
        end
        req = '0;
        step();
        tx_busy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            expect_quiet(1'b0, "withdraw");
        end

        // Reset during WAIT_DONE; late tx_done must be discarded
        req = 4'b1111;
        do_grant("rstmid", w, lb);
        req = '0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        expect_reset_outputs("rstmid.async");
        step();
        rst_n   = 1'b1;
        m_ptr   = 0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        expect_quiet(1'b0, "rstmid.late_done");
        req = 4'b1111;
        do_grant("rstmid.ptr", w, lb);
        check("rstmid.ptr_owner", 32'(owner), 32'd0);
        req = '0;
        serve_frame(w, 1, 1'b0, lb, "rstmid", rl);

        // Long wait without tx_done
        req = 4'b0110;
        do_grant("wd", w, lb);
        req = '0;
`ifdef UART_ARB_TIMEOUT_EN
        step();
        expect_quiet(1'b1, "wd.launch");
        for (int c = 1; c < TO; c++) begin
            step();
            expect_quiet(1'b1, "wd.count");
        end
        step();
        check("wd.timeout_err", 32'(timeout_err), 32'd1);
        check("wd.active", 32'(active), 32'd0);
        check("wd.tx_start", 32'(tx_start), 32'd0);
        m_ptr = (w + 1) % N;
        req   = 4'b1111;
        do_grant("wd.next", w, lb);
        req = '0;
        serve_frame(w, 2, 1'b0, lb, "wd.next", rl);
`else
        serve_frame(w, 40, 1'b0, lb, "wd", rl);
`endif

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            req      = N'($urandom_range(1, (1 << N) - 1));
            req_lock = N'($urandom);
            for (int i = 0; i < N; i++) set_byte(i, DW'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                tx_busy = 1'b1;
                step();
                expect_quiet(1'b0, "rnd.busy");
                tx_busy = 1'b0;
            end
            do_grant("rnd.grant", w, lb);
            do begin
                if ($urandom_range(0, 1) == 1) set_byte(w, DW'($urandom));
                else req[w] = 1'b0;
                if ($urandom_range(0, 1) == 1) req[(w + 1) % N] = ~req[(w + 1) % N];
                serve_frame(w, $urandom_range(0, 4), $urandom_range(0, 3) == 0, lb, "rnd", rl);
                lb = get_byte(w);
            end while (rl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
